// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier with a start/busy/done handshake.
// Produces the full 2*WIDTH-bit product in WIDTH iterations. There is no early
// termination, so a zero multiplier still takes the full fixed latency.
// Optional feature macro MULT_SIGNED_EN: when defined, A and B are two's complement.
// Their magnitudes are multiplied, and the product is negated on completion if
// the signs differ.
module seq_mult_unit #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_q, out_d;

  logic [WIDTH-1:0]     a_load;
  logic [WIDTH-1:0]     b_load;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   result;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    a_load = A[WIDTH-1] ? (~A + 1'b1) : A;
    b_load = B[WIDTH-1] ? (~B + 1'b1) : B;
    result = neg_q ? (~acc_sum + 1'b1) : acc_sum;
  end
`else
  always_comb begin
    a_load = A;
    b_load = B;
    result = acc_sum;
  end
`endif

  // Partial-product accumulate for the current multiplier bit.
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
`ifdef MULT_SIGNED_EN
    neg_d    = neg_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_load};
          mplier_d = b_load;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
`endif
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final add is folded straight into out on the completion edge.
        if (cnt_q == LAST_CNT) begin
          out_d   = result;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
`ifdef MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;

`ifdef MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  A = '0;
  logic [3:0]  B = '0;
  logic        busy;
  logic        done;
  logic [7:0]  out;

  logic        start8 = 1'b0;
  logic [7:0]  A8 = '0;
  logic [7:0]  B8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] out8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] exp;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  seq_mult_unit #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .out(out)
  );

  seq_mult_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .out(out8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ex(input logic [15:0] u, input logic [15:0] s);
    return SGN ? s : u;
  endfunction

  // Scoreboard monitors: pop on every done pulse, check product and latency.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("product4", 32'(out), 32'(e.exp[7:0]));
        check("latency4", 32'(cyc - e.cyc), 32'd5);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 32'(done8), 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("product8", 32'(out8), 32'(e.exp));
        check("latency8", 32'(cyc - e.cyc), 32'd9);
      end
    end
  end

  // One WIDTH=4 operation: busy length, start pulse during RUN ignored, out holds.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int n;
    int t;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    q4.push_back('{exp: 16'(exp), cyc: cyc});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    t = 0;
    while (busy === 1'b1 && t < 20) begin
      n++;
      A = 4'($urandom);
      B = 4'($urandom);
      start = (n == 2);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("busy_cycles4", 32'(n), 32'd4);
    @(negedge clk);
    check("out_hold4", 32'(out), 32'(exp));
    check("done_low4", 32'(done), 32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((q4.size() != 0 || q8.size() != 0) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain4", 32'(q4.size()), 32'd0);
    check("drain8", 32'(q8.size()), 32'd0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out8", 32'(out8), 32'd0);
    rst = 1'b0;

    run_op(4'hF, 4'hF, 8'(ex(16'hE1, 16'h01)));
    run_op(4'h0, 4'h9, 8'h00);
    run_op(4'h9, 4'h0, 8'h00);
    run_op(4'hD, 4'h5, 8'(ex(16'h41, 16'hF1)));
    run_op(4'h8, 4'h8, 8'h40);
    run_op(4'h8, 4'h7, 8'(ex(16'h38, 16'hC8)));

    // Back-to-back: second operands presented on the DONE cycle with start held.
    @(negedge clk);
    A = 4'd3; B = 4'd5; start = 1'b1;
    q4.push_back('{exp: 16'h0F, cyc: cyc});
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == 2) begin A = 4'hF; B = 4'hF; end
    end while (done !== 1'b1 && t < 20);
    check("b2b_first_done_seen", 32'(done), 32'd1);
    A = 4'd7; B = 4'd6;
    q4.push_back('{exp: 16'h2A, cyc: cyc});
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b1; A = 4'hC; B = 4'hC;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    A = 4'd12; B = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    run_op(4'h1, 4'h1, 8'h01);

    // WIDTH=8 instance.
    @(negedge clk);
    A8 = 8'hFF; B8 = 8'hFF; start8 = 1'b1;
    q8.push_back('{exp: ex(16'hFE01, 16'h0001), cyc: cyc});
    @(negedge clk);
    start8 = 1'b0;
    t = 0;
    while (q8.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    A8 = 8'h80; B8 = 8'h80; start8 = 1'b1;
    q8.push_back('{exp: 16'h4000, cyc: cyc});
    @(negedge clk);
    start8 = 1'b0;
    drain();
    @(negedge clk);
    check("out8_hold", 32'(out8), 32'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
